// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared encodings for the branch predict unit: PC select
//               codes, EX jump kinds, 2-bit counter states and the
//               saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

   // PC select mux encodings
   localparam logic [1:0] PC_SEL_PC4   = 2'b00;
   localparam logic [1:0] PC_SEL_PRED  = 2'b01;
   localparam logic [1:0] PC_SEL_REDIR = 2'b10;

   // EX jump kind; 2'b11 is reserved and behaves as JUMP_NONE
   localparam logic [1:0] JUMP_NONE = 2'b00;
   localparam logic [1:0] JUMP_JAL  = 2'b01;
   localparam logic [1:0] JUMP_JALR = 2'b10;

   // 2-bit counter states
   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Saturating step toward the resolved outcome
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ============================================================================
// Module      : bht_2bit
// Description : Branch history table of 2-bit saturating counters.
//               Asynchronous read, synchronous write, asynchronous reset.
//               A write is visible to reads from the following cycle only.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (all -> CTR_INIT)
//               rd_idx   - lookup index
//               rd_ctr   - counter at rd_idx
//               wr_en    - update enable
//               wr_idx   - update index
//               wr_taken - resolved outcome (step up if 1, down if 0)
// Revision    : 1.0 - initial release
// ============================================================================
module bht_2bit
   import branch_pkg::*;
#(
   parameter int         IDX_BITS = 6,
   parameter logic [1:0] CTR_INIT = 2'b01
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [1:0]          rd_ctr,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);

   localparam int DEPTH = 2 ** IDX_BITS;

   logic [1:0] r_ctr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ctr[i] <= CTR_INIT;
         end
      end else if (wr_en) begin
         r_ctr[wr_idx] <= ctr_next(r_ctr[wr_idx], wr_taken);
      end
   end

   // No write-to-read bypass: a lookup sees the pre-update value
   assign rd_ctr = r_ctr[rd_idx];

endmodule : bht_2bit
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : IF-stage 2-bit BHT prediction, EX-stage redirect/flush
//               generation and branch performance counters.
// Ports       : clk, reset_br (async, active-high), stall
//               IF : if_is_branch, if_pc -> pred_taken
//               EX : ex_valid, ex_pc, ex_taken, ex_pred_taken, ex_target,
//                    ex_jalr_target, ex_jump
//               PC : pc_sel, redirect_pc, IF_Flush, ID_Flush
//               Stats: clr_stats -> br_count, mispred_count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int         ADDR_W   = 32,
   parameter int         IDX_BITS = 6,
   parameter logic [1:0] CTR_INIT = 2'b01,
   parameter int         COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset_br,
   input  logic               stall,
   input  logic               if_is_branch,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic               ex_valid,
   input  logic [ADDR_W-1:0]  ex_pc,
   input  logic               ex_taken,
   input  logic               ex_pred_taken,
   input  logic [ADDR_W-1:0]  ex_target,
   input  logic [ADDR_W-1:0]  ex_jalr_target,
   input  logic [1:0]         ex_jump,
   input  logic               clr_stats,
   output logic               pred_taken,
   output logic [1:0]         pc_sel,
   output logic [ADDR_W-1:0]  redirect_pc,
   output logic               IF_Flush,
   output logic               ID_Flush,
   output logic [COUNT_W-1:0] br_count,
   output logic [COUNT_W-1:0] mispred_count
);

   logic [1:0] w_rd_ctr;
   logic       w_mispredict;
   logic       w_bht_we;
   logic       w_unused;

   assign w_mispredict = ex_valid & (ex_taken != ex_pred_taken);
   assign w_bht_we     = ex_valid & ~stall;

   bht_2bit #(
      .IDX_BITS (IDX_BITS),
      .CTR_INIT (CTR_INIT)
   ) u_bht (
      .clk      (clk),
      .rst      (reset_br),
      .rd_idx   (if_pc[IDX_BITS+1:2]),
      .rd_ctr   (w_rd_ctr),
      .wr_en    (w_bht_we),
      .wr_idx   (ex_pc[IDX_BITS+1:2]),
      .wr_taken (ex_taken)
   );

   // Prediction is the counter MSB; forced low while reset is held
   assign pred_taken = ~reset_br & if_is_branch & w_rd_ctr[1];

   // EX redirects take precedence over the IF prediction; stall does not
   // suppress a redirect since the wrong-path fetch must still be killed.
   always_comb begin
      pc_sel      = PC_SEL_PC4;
      redirect_pc = '0;
      IF_Flush    = 1'b0;
      ID_Flush    = 1'b0;
      if (!reset_br) begin
         if (ex_jump == JUMP_JALR) begin
            pc_sel      = PC_SEL_REDIR;
            redirect_pc = ex_jalr_target;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
         end else if (ex_jump == JUMP_JAL) begin
            pc_sel      = PC_SEL_REDIR;
            redirect_pc = ex_target;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
         end else if (w_mispredict && ex_taken) begin
            pc_sel      = PC_SEL_REDIR;
            redirect_pc = ex_target;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
         end else if (w_mispredict) begin
            pc_sel      = PC_SEL_REDIR;
            redirect_pc = ex_pc + ADDR_W'(4);
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
         end else if (pred_taken) begin
            pc_sel      = PC_SEL_PRED;
         end
      end
   end

   // Performance counters; clear wins over increment, wrap is natural
   always_ff @(posedge clk or posedge reset_br) begin
      if (reset_br) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (clr_stats) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (!stall) begin
         br_count      <= br_count + COUNT_W'(ex_valid);
         mispred_count <= mispred_count + COUNT_W'(w_mispredict);
      end
   end

   // PC bits outside the BHT index and the counter LSB carry no prediction info
   assign w_unused = ^{if_pc[ADDR_W-1:IDX_BITS+2], if_pc[1:0], w_rd_ctr[0]};

endmodule : branch_predict_unit
`default_nettype wire
